// File: rtl/fetch_decode_buffer.sv
// Fetch-to-decode decoupling FIFO: buffers {pc, instr} pairs, presents the oldest to decode,
// and drops all buffered wrong-path entries on a redirect flush.
module fetch_decode_buffer #(
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_instr,
    output logic                       in_ready,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_instr,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [31:0]     pc_mem_q    [DEPTH];
    logic [31:0]     pc_mem_d    [DEPTH];
    logic [31:0]     instr_mem_q [DEPTH];
    logic [31:0]     instr_mem_d [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push, pop;

    // Ready depends on occupancy only; a full buffer never passes through on a same-cycle pop.
    assign in_ready  = (count_q != CntW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign count     = count_q;

    always_comb begin
        out_pc    = 32'h0;
        out_instr = NOP_INSTR;
        if (out_valid) begin
            out_pc    = pc_mem_q[rd_ptr_q];
            out_instr = instr_mem_q[rd_ptr_q];
        end
    end

    always_comb begin
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push) begin
            pc_mem_d[wr_ptr_q]    = in_pc;
            instr_mem_d[wr_ptr_q] = in_instr;
            wr_ptr_d              = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
        // Memory is left intact on flush; pointers and count alone define validity.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        pc_mem_q    <= pc_mem_d;
        instr_mem_q <= instr_mem_d;
    end

endmodule

// File: doc/fetch_decode_buffer.md
Name: fetch_decode_buffer

Overview:
- Decoupling buffer between the fetch stage and the decode stage.
- Captures each fetched {pc, instruction} pair into a small FIFO and presents the oldest entry to decode with a valid/ready handshake.
- Absorbs decode back-pressure so fetch can keep issuing memory requests.
- Discards all buffered, wrong-path instructions when the branch unit redirects the PC.

Parameters:
- DEPTH, 2, number of entries; power of two, minimum 2.
- NOP_INSTR, 32'h00000013, value driven on out_instr when no entry is valid (addi x0,x0,0).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  fetch presents a returned instruction this cycle.
- in_pc  input  32  PC of the presented instruction.
- in_instr  input  32  presented instruction word.
- in_ready  output  1  buffer can accept an entry this cycle.
- flush  input  1  redirect (taken branch/jump); discard contents and any same-cycle input.
- out_valid  output  1  head entry valid for decode.
- out_pc  output  32  PC of head entry.
- out_instr  output  32  instruction of head entry; NOP_INSTR when out_valid=0.
- out_ready  input  1  decode consumes head this cycle.
- count  output  $clog2(DEPTH+1)  number of valid entries.

Behaviour:
- Storage: circular array of DEPTH {pc, instr} entries.
  - Pointers: wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - Occupancy counter: count, 0..DEPTH.
- push = in_valid && in_ready && !flush.
- pop = out_valid && out_ready && !flush.
- in_ready = (count != DEPTH). It is combinational from state only and does not depend on out_ready. There is no pass-through when full.
- out_valid = (count != 0).
- out_pc and out_instr are driven combinationally from mem[rd_ptr] when out_valid=1. When out_valid=0, out_pc=0 and out_instr=NOP_INSTR.
- Latency: an entry pushed at edge N is visible on out_* in the cycle after edge N. Minimum in-to-out latency is 1 cycle; there is no combinational in-to-out path.
- On push: write mem[wr_ptr], then wr_ptr+1.
- On pop: rd_ptr+1.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged. This is legal only when 0<count<DEPTH.
- Empty (count=0): pop cannot occur because out_valid=0. A push makes the entry visible next cycle.
- Full (count=DEPTH): in_ready=0, so an in_valid from fetch is ignored. Fetch must hold or re-request the instruction. A pop in this cycle frees one slot, and in_ready returns to 1 next cycle.
- Flush (sampled at the edge):
  - wr_ptr, rd_ptr and count go to 0.
  - The same-cycle input is dropped and the same-cycle pop does not occur.
  - Next cycle: out_valid=0 and in_ready=1.
  - mem contents are not cleared.
- Reset (rst=1 at the edge): highest priority, overrides flush, push and pop.
  - State after reset: count=0, pointers=0, out_valid=0, out_pc=0, out_instr=NOP_INSTR, in_ready=1.
  - Reset asserted mid-stream discards all entries.
- Pointer wrap: after DEPTH pushes, wr_ptr returns to 0. Order must be preserved across the wrap.
- No X propagation: mem entries are written before being read, and outputs are masked when empty.

Test Plan:
- Reset check: rst=1 for 2 cycles, then release -> out_valid=0, out_instr=32'h00000013, out_pc=0, in_ready=1, count=0.
- Single transfer: push pc=0x00000000 instr=0x00500093 with out_ready=1 -> next cycle out_valid=1 and out_pc=0x0 / out_instr=0x00500093; following cycle out_valid=0.
- Back-pressure fill: out_ready=0, push pc 0x0 and 0x4 -> count=2, in_ready=0. Offered pc 0x8 is ignored. Raise out_ready -> outputs are 0x0 then 0x4, in order.
- Streaming with wrap: out_ready=1 and in_valid=1 every cycle for pc 0x0..0x1C (8 entries) -> out_pc sequence 0x0,0x4,...,0x1C with no gaps after the first cycle, count stays at 1.
- Flush with simultaneous push/pop: count=2, flush=1 with in_valid=1 (pc 0x40) and out_ready=1 -> next cycle count=0 and out_valid=0. Pc 0x40 is never output.
- Reset mid-operation: count=2, rst=1 together with flush=0 and in_valid=1 -> next cycle count=0 and out_valid=0. The first push after reset (pc 0x100) is output as the next valid entry.
